// File: rtl/axi_pkg.sv
// Shared AXI3 encodings, widths and FSM state types for the RAM responder.
package axi_pkg;

    localparam int AXI_ID_W  = 4;
    localparam int AXI_LEN_W = 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for one AXI channel, plus an error flag
// for reserved burst types and sizes wider than the 32-bit data bus.
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [31:0]          addr,
    input  logic [2:0]           size,
    input  logic [AXI_LEN_W-1:0] len,
    input  logic [1:0]           burst,
    output logic [31:0]          next_addr,
    output logic                 bad_burst
);

    logic [1:0]  eff_size;
    logic [31:0] step;
    logic [31:0] incr_addr;
    logic [31:0] span_mask;

    // Step is clamped to a full word; WRAP keeps the upper bits and wraps the low log2(span) bits
    always_comb begin
        eff_size  = (size > 3'd2) ? 2'd2 : size[1:0];
        step      = 32'd1 << eff_size;
        incr_addr = addr + step;
        span_mask = (({{(32-AXI_LEN_W){1'b0}}, len} + 32'd1) << eff_size) - 32'd1;
        bad_burst = (burst == BURST_RSVD) || (size > 3'd2);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~span_mask) | (incr_addr & span_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI3 slave RAM: independent read and write FSMs sharing one simple
// dual-port word array. Reads are registered and read-first against writes.
module axi_ram_responder
    import axi_pkg::*;
#(
    parameter int    MEM_ADDR_BITS = 14,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AXI_ID_W-1:0]  arid,
    input  logic [31:0]          araddr,
    input  logic [AXI_LEN_W-1:0] arlen,
    input  logic [2:0]           arsize,
    input  logic [1:0]           arburst,
    input  logic [1:0]           arlock,
    input  logic [3:0]           arcache,
    input  logic [2:0]           arprot,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [AXI_ID_W-1:0]  rid,
    output logic [31:0]          rdata,
    output logic [1:0]           rresp,
    output logic                 rlast,
    output logic                 rvalid,
    input  logic                 rready,
    input  logic [AXI_ID_W-1:0]  awid,
    input  logic [31:0]          awaddr,
    input  logic [AXI_LEN_W-1:0] awlen,
    input  logic [2:0]           awsize,
    input  logic [1:0]           awburst,
    input  logic [1:0]           awlock,
    input  logic [3:0]           awcache,
    input  logic [2:0]           awprot,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [AXI_ID_W-1:0]  wid,
    input  logic [31:0]          wdata,
    input  logic [3:0]           wstrb,
    input  logic                 wlast,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [AXI_ID_W-1:0]  bid,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready
);

    localparam int MEM_WORDS = 1 << MEM_ADDR_BITS;

    logic [31:0] mem [MEM_WORDS];

    logic unused_inputs;
    assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    logic ready_pre_q, ready_pre_d, ready_en_q, ready_en_d;

    rd_state_e              rd_state_q, rd_state_d;
    logic [AXI_ID_W-1:0]    rd_id_q, rd_id_d;
    logic [31:0]            rd_addr_q, rd_addr_d;
    logic [AXI_LEN_W-1:0]   rd_len_q, rd_len_d, rd_beat_q, rd_beat_d;
    logic [2:0]             rd_size_q, rd_size_d;
    logic [1:0]             rd_burst_q, rd_burst_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            rd_next_addr;
    logic                   rd_bad, rd_last, rd_en;
    logic [MEM_ADDR_BITS-1:0] rd_idx;

    wr_state_e              wr_state_q, wr_state_d;
    logic [AXI_ID_W-1:0]    wr_id_q, wr_id_d;
    logic [31:0]            wr_addr_q, wr_addr_d;
    logic [AXI_LEN_W-1:0]   wr_len_q, wr_len_d, wr_beat_q, wr_beat_d;
    logic [2:0]             wr_size_q, wr_size_d;
    logic [1:0]             wr_burst_q, wr_burst_d;
    logic                   wr_err_q, wr_err_d;
    logic [31:0]            wr_next_addr;
    logic                   wr_bad, wr_last, mem_we;
    logic [MEM_ADDR_BITS-1:0] wr_idx;

    axi_burst_addr u_rd_addr (
        .addr      (rd_addr_q),
        .size      (rd_size_q),
        .len       (rd_len_q),
        .burst     (rd_burst_q),
        .next_addr (rd_next_addr),
        .bad_burst (rd_bad)
    );

    axi_burst_addr u_wr_addr (
        .addr      (wr_addr_q),
        .size      (wr_size_q),
        .len       (wr_len_q),
        .burst     (wr_burst_q),
        .next_addr (wr_next_addr),
        .bad_burst (wr_bad)
    );

    assign rd_last = (rd_beat_q == rd_len_q);
    assign wr_last = (wr_beat_q == wr_len_q);
    assign wr_idx  = wr_addr_q[MEM_ADDR_BITS+1:2];

    // Address readiness comes up two clock edges after reset release
    always_comb begin
        ready_pre_d = 1'b1;
        ready_en_d  = ready_pre_q;
    end

    // Read FSM: accept AR, then stream beats; the RAM is only read when a new beat is needed
    always_comb begin
        rd_state_d = rd_state_q;
        rd_id_d    = rd_id_q;
        rd_addr_d  = rd_addr_q;
        rd_len_d   = rd_len_q;
        rd_size_d  = rd_size_q;
        rd_burst_d = rd_burst_q;
        rd_beat_d  = rd_beat_q;
        rd_en      = 1'b0;
        rd_idx     = rd_addr_q[MEM_ADDR_BITS+1:2];
        arready    = 1'b0;
        rvalid     = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                arready = ready_en_q;
                if (arvalid && ready_en_q) begin
                    rd_id_d    = arid;
                    rd_addr_d  = araddr;
                    rd_len_d   = arlen;
                    rd_size_d  = arsize;
                    rd_burst_d = arburst;
                    rd_beat_d  = '0;
                    rd_en      = 1'b1;
                    rd_idx     = araddr[MEM_ADDR_BITS+1:2];
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) begin
                    if (rd_last) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_addr_d = rd_next_addr;
                        rd_beat_d = rd_beat_q + AXI_LEN_W'(1);
                        rd_en     = 1'b1;
                        rd_idx    = rd_next_addr[MEM_ADDR_BITS+1:2];
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        rdata_d = rd_en ? mem[rd_idx] : rdata_q;
    end

    // Write FSM: accept AW, absorb exactly len+1 beats, then hold the response until taken
    always_comb begin
        wr_state_d = wr_state_q;
        wr_id_d    = wr_id_q;
        wr_addr_d  = wr_addr_q;
        wr_len_d   = wr_len_q;
        wr_size_d  = wr_size_q;
        wr_burst_d = wr_burst_q;
        wr_beat_d  = wr_beat_q;
        wr_err_d   = wr_err_q;
        mem_we     = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                awready = ready_en_q;
                if (awvalid && ready_en_q) begin
                    wr_id_d    = awid;
                    wr_addr_d  = awaddr;
                    wr_len_d   = awlen;
                    wr_size_d  = awsize;
                    wr_burst_d = awburst;
                    wr_beat_d  = '0;
                    wr_err_d   = 1'b0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_we = 1'b1;
                    if (wlast != wr_last) begin
                        wr_err_d = 1'b1;
                    end
                    if (wr_last) begin
                        wr_state_d = W_RESP;
                    end else begin
                        wr_addr_d = wr_next_addr;
                        wr_beat_d = wr_beat_q + AXI_LEN_W'(1);
                    end
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // State and context registers; reset aborts any burst in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_pre_q <= 1'b0;
            ready_en_q  <= 1'b0;
            rd_state_q  <= R_IDLE;
            rd_id_q     <= '0;
            rd_addr_q   <= '0;
            rd_len_q    <= '0;
            rd_size_q   <= '0;
            rd_burst_q  <= '0;
            rd_beat_q   <= '0;
            rdata_q     <= '0;
            wr_state_q  <= W_IDLE;
            wr_id_q     <= '0;
            wr_addr_q   <= '0;
            wr_len_q    <= '0;
            wr_size_q   <= '0;
            wr_burst_q  <= '0;
            wr_beat_q   <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            ready_pre_q <= ready_pre_d;
            ready_en_q  <= ready_en_d;
            rd_state_q  <= rd_state_d;
            rd_id_q     <= rd_id_d;
            rd_addr_q   <= rd_addr_d;
            rd_len_q    <= rd_len_d;
            rd_size_q   <= rd_size_d;
            rd_burst_q  <= rd_burst_d;
            rd_beat_q   <= rd_beat_d;
            rdata_q     <= rdata_d;
            wr_state_q  <= wr_state_d;
            wr_id_q     <= wr_id_d;
            wr_addr_q   <= wr_addr_d;
            wr_len_q    <= wr_len_d;
            wr_size_q   <= wr_size_d;
            wr_burst_q  <= wr_burst_d;
            wr_beat_q   <= wr_beat_d;
            wr_err_q    <= wr_err_d;
        end
    end

    // Byte-lane writes into the word array; no reset so contents survive it
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign rid   = rd_id_q;
    assign rlast = rvalid & rd_last;
    assign rresp = (rvalid && rd_bad) ? RESP_SLVERR : RESP_OKAY;
    assign bid   = wr_id_q;
    assign bresp = (bvalid && (wr_err_q || wr_bad)) ? RESP_SLVERR : RESP_OKAY;

endmodule
